// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths and FSM encodings for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

    localparam int RF_BUS_W  = 38;
    localparam int RF_ADDR_W = 5;
    localparam int DATA_W    = 32;
    localparam int ENTRY_W   = RF_ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_STEAL = 2'd2
    } state_t;

    function automatic logic [31:0] dest_onehot(input logic [RF_ADDR_W-1:0] addr);
        return 32'd1 << addr;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// MDU result queue: DEPTH x {addr, data} with full/count and per-entry taps
// so the top can build the pending-destination mask.
module rf_wb_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [RF_ADDR_W-1:0]         push_addr,
    input  logic [DATA_W-1:0]            push_data,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic [RF_ADDR_W-1:0]         head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH*RF_ADDR_W-1:0]   entry_addr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]         wr_ptr_reg;
    logic [AW:0]         rd_ptr_reg;
    logic [ENTRY_W-1:0]  mem_reg [DEPTH];

    // The extra pointer bit separates full from empty.
    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign full      = (count == (AW+1)'(DEPTH));
    assign head_addr = mem_reg[rd_ptr_reg[AW-1:0]][ENTRY_W-1 -: RF_ADDR_W];
    assign head_data = mem_reg[rd_ptr_reg[AW-1:0]][DATA_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= {push_addr, push_data};
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            logic [AW-1:0] offset;
            assign offset          = AW'(gi) - rd_ptr_reg[AW-1:0];
            assign entry_valid[gi] = ({1'b0, offset} < count);
            assign entry_addr[gi*RF_ADDR_W +: RF_ADDR_W] = mem_reg[gi][ENTRY_W-1 -: RF_ADDR_W];
        end
    endgenerate

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port between WB (priority) and queued MDU results,
// stealing the port from WB when the oldest MDU result has waited too long.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [RF_BUS_W-1:0]  wb_regfile_bus,
    output logic                 wb_hold,
    input  logic                 mdu_valid,
    output logic                 mdu_ready,
    input  logic [RF_ADDR_W-1:0] mdu_waddr,
    input  logic [DATA_W-1:0]    mdu_wdata,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [31:0]          pend_dest_mask,
    output logic [15:0]          steal_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [4:0] STEAL_AT = 5'(MAX_WAIT - 1);

    logic                       wb_we;
    logic [RF_ADDR_W-1:0]       wb_waddr;
    logic [DATA_W-1:0]          wb_wdata;
    logic                       full;
    logic [CW-1:0]              count;
    logic [RF_ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]          head_data;
    logic [DEPTH-1:0]           entry_valid;
    logic [DEPTH*RF_ADDR_W-1:0] entry_addr;
    logic                       push;
    logic                       grant;
    logic                       remain;
    logic [4:0]                 wait_inc;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] steal_cnt_reg, steal_cnt_next;

    assign wb_we    = wb_regfile_bus[37];
    assign wb_waddr = wb_regfile_bus[36:32];
    assign wb_wdata = wb_regfile_bus[31:0];

    // r0 results are acknowledged but never stored.
    assign mdu_ready = ~full;
    assign push      = mdu_valid & ~full & (mdu_waddr != '0);

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push),
        .pop         (grant),
        .push_addr   (mdu_waddr),
        .push_data   (mdu_wdata),
        .full        (full),
        .count       (count),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    assign remain   = (count > CW'(1)) | push;
    assign wait_inc = {1'b0, wait_cnt_reg} + 5'd1;
    assign wb_hold  = (state_reg == ST_STEAL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            steal_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            steal_cnt_reg <= steal_cnt_next;
        end
    end

    always_comb begin
        grant          = 1'b0;
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        steal_cnt_next = steal_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (push) state_next = ST_PEND;
            end
            ST_PEND: begin
                if (!wb_we) begin
                    grant         = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = remain ? ST_PEND : ST_IDLE;
                end else begin
                    wait_cnt_next = wait_inc[3:0];
                    if (wait_inc >= STEAL_AT) state_next = ST_STEAL;
                end
            end
            ST_STEAL: begin
                grant          = 1'b1;
                wait_cnt_next  = '0;
                steal_cnt_next = (&steal_cnt_reg) ? steal_cnt_reg : steal_cnt_reg + 16'd1;
                state_next     = remain ? ST_PEND : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rf_we     = grant | (wb_we & ~wb_hold);
    assign rf_waddr  = grant ? head_addr : wb_waddr;
    assign rf_wdata  = grant ? head_data : wb_wdata;
    assign steal_cnt = steal_cnt_reg;

    always_comb begin
        pend_dest_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i])
                pend_dest_mask = pend_dest_mask | dest_onehot(entry_addr[i*RF_ADDR_W +: RF_ADDR_W]);
        end
        pend_dest_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: a per-cycle vector table plus hand
// sequences for FIFO back-pressure/ordering and asynchronous reset.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [37:0] wb_regfile_bus;
    logic        wb_hold;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_dest_mask;
    logic [15:0] steal_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_regfile_bus (wb_regfile_bus),
        .wb_hold        (wb_hold),
        .mdu_valid      (mdu_valid),
        .mdu_ready      (mdu_ready),
        .mdu_waddr      (mdu_waddr),
        .mdu_wdata      (mdu_wdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pend_dest_mask (pend_dest_mask),
        .steal_cnt      (steal_cnt)
    );

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_hold;
        logic        e_ready;
        logic [31:0] e_mask;
        logic [15:0] e_steal;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [31:0] d,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                                input logic eh, input logic er, input logic [31:0] em,
                                input logic [15:0] es);
        vec_t v;
        v.wb_we = we;  v.wb_addr = a;  v.wb_data = d;
        v.mv = mv;     v.ma = ma;      v.md = md;
        v.e_we = ewe;  v.e_addr = ea;  v.e_data = ed;
        v.e_hold = eh; v.e_ready = er; v.e_mask = em; v.e_steal = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        @(negedge clk);
        wb_regfile_bus = {we, a, d};
        mdu_valid      = mv;
        mdu_waddr      = ma;
        mdu_wdata      = md;
        #1;
    endtask

    task automatic chk_write(input string tag, input logic ewe, input logic [4:0] ea,
                             input logic [31:0] ed);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(ewe));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(ea));
        chk({tag, ".rf_wdata"}, rf_wdata, ed);
        $display("%s: rf_we=%b waddr=%0d wdata=%h hold=%b ready=%b mask=%h steal=%0d",
                 tag, rf_we, rf_waddr, rf_wdata, wb_hold, mdu_ready, pend_dest_mask, steal_cnt);
    endtask

    initial begin
        vt[0]  = mk(1, 5, 32'h1234, 0, 0, 0,          1, 5, 32'h1234, 0, 1, 32'h0,  16'd0);
        vt[1]  = mk(1, 5, 32'h1234, 0, 0, 0,          1, 5, 32'h1234, 0, 1, 32'h0,  16'd0);
        vt[2]  = mk(1, 5, 32'h1234, 0, 0, 0,          1, 5, 32'h1234, 0, 1, 32'h0,  16'd0);
        vt[3]  = mk(0, 0, 32'h0,    1, 7, 32'hDEAD,   0, 0, 32'h0,    0, 1, 32'h0,  16'd0);
        vt[4]  = mk(0, 0, 32'h0,    0, 0, 0,          1, 7, 32'hDEAD, 0, 1, 32'h80, 16'd0);
        vt[5]  = mk(0, 0, 32'h0,    0, 0, 0,          0, 0, 32'h0,    0, 1, 32'h0,  16'd0);
        vt[6]  = mk(0, 0, 32'h0,    1, 0, 32'hFFFF,   0, 0, 32'h0,    0, 1, 32'h0,  16'd0);
        vt[7]  = mk(0, 0, 32'h0,    0, 0, 0,          0, 0, 32'h0,    0, 1, 32'h0,  16'd0);
        vt[8]  = mk(1, 5, 32'h1234, 1, 3, 32'hBEEF,   1, 5, 32'h1234, 0, 1, 32'h0,  16'd0);
        vt[9]  = mk(1, 5, 32'h1,    0, 0, 0,          1, 5, 32'h1,    0, 1, 32'h8,  16'd0);
        vt[10] = mk(1, 5, 32'h2,    0, 0, 0,          1, 5, 32'h2,    0, 1, 32'h8,  16'd0);
        vt[11] = mk(1, 5, 32'h3,    0, 0, 0,          1, 5, 32'h3,    0, 1, 32'h8,  16'd0);
        vt[12] = mk(1, 6, 32'h4,    0, 0, 0,          1, 3, 32'hBEEF, 1, 1, 32'h8,  16'd0);
        vt[13] = mk(1, 6, 32'h4,    0, 0, 0,          1, 6, 32'h4,    0, 1, 32'h0,  16'd1);

        resetn         = 1'b0;
        wb_regfile_bus = '0;
        mdu_valid      = 1'b0;
        mdu_waddr      = '0;
        mdu_wdata      = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.rf_we", 32'(rf_we), 32'd0);
        chk("rst.wb_hold", 32'(wb_hold), 32'd0);
        chk("rst.mdu_ready", 32'(mdu_ready), 32'd1);
        chk("rst.mask", pend_dest_mask, 32'h0);
        chk("rst.steal_cnt", 32'(steal_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].wb_we, vt[i].wb_addr, vt[i].wb_data, vt[i].mv, vt[i].ma, vt[i].md);
            chk($sformatf("vec%0d.wb_hold", i), 32'(wb_hold), 32'(vt[i].e_hold));
            chk($sformatf("vec%0d.mdu_ready", i), 32'(mdu_ready), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d.mask", i), pend_dest_mask, vt[i].e_mask);
            chk($sformatf("vec%0d.steal_cnt", i), 32'(steal_cnt), 32'(vt[i].e_steal));
            chk_write($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_addr, vt[i].e_data);
        end

        // FIFO full back-pressure and strict drain order r1, r2, r3.
        drive(1, 5, 32'h100, 1, 1, 32'h11);
        chk("q0.ready", 32'(mdu_ready), 32'd1);
        drive(1, 5, 32'h101, 1, 2, 32'h22);
        chk("q1.ready", 32'(mdu_ready), 32'd1);
        chk("q1.mask", pend_dest_mask, 32'h2);
        drive(1, 5, 32'h102, 1, 3, 32'h33);
        chk("q2.ready", 32'(mdu_ready), 32'd0);
        chk("q2.mask", pend_dest_mask, 32'h6);
        chk_write("q2", 1, 5, 32'h102);
        drive(1, 5, 32'h103, 1, 3, 32'h33);
        chk("q3.ready", 32'(mdu_ready), 32'd0);
        chk("q3.hold", 32'(wb_hold), 32'd0);
        drive(1, 6, 32'h104, 1, 3, 32'h33);
        chk("q4.hold", 32'(wb_hold), 32'd1);
        chk("q4.ready", 32'(mdu_ready), 32'd0);
        chk_write("q4", 1, 1, 32'h11);
        drive(1, 6, 32'h104, 1, 3, 32'h33);
        chk("q5.hold", 32'(wb_hold), 32'd0);
        chk("q5.ready", 32'(mdu_ready), 32'd1);
        chk("q5.mask", pend_dest_mask, 32'h4);
        chk("q5.steal_cnt", 32'(steal_cnt), 32'd2);
        chk_write("q5", 1, 6, 32'h104);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("q6.mask", pend_dest_mask, 32'hC);
        chk_write("q6", 1, 2, 32'h22);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("q7.mask", pend_dest_mask, 32'h8);
        chk_write("q7", 1, 3, 32'h33);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("q8.mask", pend_dest_mask, 32'h0);
        chk_write("q8", 0, 0, 32'h0);

        // Asynchronous reset while stealing with two entries queued.
        drive(1, 5, 32'h200, 1, 1, 32'h11);
        drive(1, 5, 32'h201, 1, 2, 32'h22);
        drive(1, 5, 32'h202, 0, 0, 32'h0);
        chk("r2.ready", 32'(mdu_ready), 32'd0);
        chk("r2.mask", pend_dest_mask, 32'h6);
        drive(1, 5, 32'h203, 0, 0, 32'h0);
        drive(1, 6, 32'h204, 0, 0, 32'h0);
        chk("r4.hold", 32'(wb_hold), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("ar.hold", 32'(wb_hold), 32'd0);
        chk("ar.ready", 32'(mdu_ready), 32'd1);
        chk("ar.mask", pend_dest_mask, 32'h0);
        chk("ar.steal_cnt", 32'(steal_cnt), 32'd0);
        chk_write("ar", 1, 6, 32'h204);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 32'h0, 0, 0, 32'h0);
            chk($sformatf("post%0d.mask", i), pend_dest_mask, 32'h0);
            chk_write($sformatf("post%0d", i), 0, 0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
